uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, number of data bits per frame (1..16).
REQ-002 Parameter CLKS_PER_BIT, default 1085, clock cycles per bit period (125 MHz / 115200 baud); legal range >= 2.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; asserts immediately, releases synchronously to clk.
REQ-005 start  input  1  transmit request, sampled only while IDLE.
REQ-006 din  input  DATA_WIDTH  byte to send, captured on the accepted start cycle.
REQ-007 serial_tx  output  1  registered serial line, idle high.
REQ-008 done  output  1  registered one-cycle pulse at frame completion.

Function
REQ-009 The FSM SHALL have states IDLE, START, DATA, PARITY (only when the parity feature is enabled) and STOP.
REQ-010 In IDLE with start=1 at a rising edge, the block SHALL latch din into a shift register, clear the bit-period counter, and enter START.
REQ-011 serial_tx SHALL go low on the edge that accepts start, one cycle after start is sampled high.
REQ-012 Each bit SHALL be held for exactly CLKS_PER_BIT clocks; the counter SHALL count 0..CLKS_PER_BIT-1, then wrap to 0 on the bit transition.
REQ-013 START SHALL drive 0 for one bit period, then DATA.
REQ-014 DATA SHALL send DATA_WIDTH bits LSB first, then go to PARITY or STOP; the bit index SHALL count 0..DATA_WIDTH-1.
REQ-015 STOP SHALL drive 1 for one bit period, then return to IDLE.
REQ-016 done SHALL be 1 for exactly the first clock in IDLE after STOP completes, and 0 at all other times.
REQ-017 A start in the cycle that done is high SHALL be accepted, so back-to-back frames have no idle gap.
REQ-018 start and din changes SHALL be ignored outside IDLE; the latched data SHALL not change mid-frame.
REQ-019 Frame length SHALL be (DATA_WIDTH+2)*CLKS_PER_BIT clocks, or (DATA_WIDTH+3)*CLKS_PER_BIT with parity.
REQ-020 Counter widths SHALL be $clog2(CLKS_PER_BIT) and $clog2(DATA_WIDTH)+1, and SHALL NOT overflow at the parameter extremes.
REQ-021 Holding start high continuously SHALL produce consecutive frames, each with its own done pulse.

Reset
REQ-022 While reset=0: state IDLE, serial_tx=1, done=0, and counters and shift register cleared.
REQ-023 Reset asserted mid-frame SHALL abort the frame at once, force serial_tx=1, and produce no done pulse.
REQ-024 After release, the block SHALL accept start on the first clock edge.

Configuration
REQ-025 Macro UART_TX_PARITY_EN, when defined, SHALL insert a PARITY state after DATA.
REQ-026 PARITY SHALL drive the even-parity bit (XOR of the latched data) for one bit period.
REQ-027 When UART_TX_PARITY_EN is undefined, no PARITY state or logic SHALL exist, and DATA SHALL go directly to STOP.

Verification
REQ-028 Reset and default parameters -> serial_tx=1 and done=0 throughout reset and in IDLE.
REQ-029 Defaults, start pulse one clock with din=0xA7 -> line holds 0,1,1,1,0,0,1,0,1,1 at 1085-clock spacing. A single done pulse follows 10850 clocks after the first low cycle.
REQ-030 CLKS_PER_BIT=4, two frames 0x00 then 0xFF with start driven high in the done cycle -> contiguous 80-clock waveform with no idle gap and two done pulses.
REQ-031 CLKS_PER_BIT=4, din changed and start re-pulsed mid-frame -> frame bits unchanged and no extra frame.
REQ-032 CLKS_PER_BIT=4, reset asserted during data bit 3 -> serial_tx=1 immediately, no done pulse, and the next start sends a clean frame.
REQ-033 UART_TX_PARITY_EN defined, din=0xA7 -> parity bit 1 after the MSB, done 11*CLKS_PER_BIT clocks after start.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional even parity, one stop bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
//
// state  | meaning
// IDLE   | line high, waiting for start
// START  | start bit (0) for one bit period
// DATA   | data bits, LSB first, one bit period each
// PARITY | even-parity bit (UART_TX_PARITY_EN only)
// STOP   | stop bit (1) for one bit period
module uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 1085
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  serial_tx,
    output logic                  done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  tx_q, tx_d;
    logic                  done_q, done_d;
    logic                  bit_end;
`ifdef UART_TX_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        done_d   = 1'b0;
        bit_end  = (cnt_q == CNT_LAST);
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = START;
                    cnt_d    = '0;
                    idx_d    = '0;
                    shift_d  = din;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^din;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is registered from the next state so it changes on the same edge as the state.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    assign serial_tx = tx_q;
    assign done      = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: default-rate A7 frame plus a fast (4 clocks/bit) instance for
// back-to-back, mid-frame interference and mid-frame reset scenarios.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
    localparam logic [10:0] A7_LINE = 11'b11101001110;
`else
    localparam int NBITS = 10;
    localparam logic [10:0] A7_LINE = 11'b01101001110;
`endif
    localparam int SLOW_CPB = 1085;
    localparam int FAST_CPB = 4;

    logic       clk;
    logic       rst_s, rst_f;
    logic       start_s, start_f;
    logic [7:0] din_s, din_f;
    logic       tx_s, tx_f;
    logic       done_s, done_f;

    int checks = 0;
    int errors = 0;

    uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(SLOW_CPB)) u_slow (
        .clk(clk), .reset(rst_s), .start(start_s), .din(din_s),
        .serial_tx(tx_s), .done(done_s)
    );

    uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(FAST_CPB)) u_fast (
        .clk(clk), .reset(rst_f), .start(start_f), .din(din_f),
        .serial_tx(tx_f), .done(done_f)
    );

    always #4 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic frame_bit(input logic [7:0] data, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return data[b-1];
        if (b == NBITS - 1) return 1'b1;
        return ^data;
    endfunction

    // Caller has start_f=1 and din_f=data set before the accepting edge; returns in the done cycle.
    task automatic fast_frame(input logic [7:0] data, input bit meddle);
        step();
        start_f = 1'b0;
        for (int b = 0; b < NBITS; b++) begin
            for (int c = 0; c < FAST_CPB; c++) begin
                if (meddle && b == 3 && c == 1) begin
                    din_f   = ~data;
                    start_f = 1'b1;
                end
                if (meddle && b == 5) start_f = 1'b0;
                chk($sformatf("fast_bit%0d_c%0d", b, c), tx_f, frame_bit(data, b));
                chk("fast_done_low", done_f, 1'b0);
                step();
            end
        end
        chk("fast_done_pulse", done_f, 1'b1);
        chk("fast_done_tx_high", tx_f, 1'b1);
    endtask

    initial begin
        clk     = 1'b0;
        rst_s   = 1'b1;
        rst_f   = 1'b1;
        start_s = 1'b0;
        start_f = 1'b0;
        din_s   = 8'h00;
        din_f   = 8'h00;
        #2;
        rst_s = 1'b0;
        rst_f = 1'b0;
        #1;
        chk("rst_tx_slow", tx_s, 1'b1);
        chk("rst_done_slow", done_s, 1'b0);
        chk("rst_tx_fast", tx_f, 1'b1);
        chk("rst_done_fast", done_f, 1'b0);
        start_f = 1'b1;
        start_s = 1'b1;
        repeat (3) begin
            step();
            chk("rst_hold_tx_slow", tx_s, 1'b1);
            chk("rst_hold_done_slow", done_s, 1'b0);
            chk("rst_hold_tx_fast", tx_f, 1'b1);
            chk("rst_hold_done_fast", done_f, 1'b0);
        end

        // Release and start on the very first edge; then back-to-back 0x00 / 0xFF.
        start_s = 1'b0;
        rst_s   = 1'b1;
        rst_f   = 1'b1;
        start_f = 1'b1;
        din_f   = 8'h00;
        fast_frame(8'h00, 1'b0);
        start_f = 1'b1;
        din_f   = 8'hFF;
        fast_frame(8'hFF, 1'b0);

        // din changed and start re-pulsed mid-frame must not disturb the frame.
        start_f = 1'b1;
        din_f   = 8'h5A;
        fast_frame(8'h5A, 1'b1);
        start_f = 1'b0;
        repeat (12) begin
            step();
            chk("fast_no_extra_tx", tx_f, 1'b1);
            chk("fast_no_extra_done", done_f, 1'b0);
        end

        // Reset during data bit 3 of 0xC3 (bit3 = 0).
        start_f = 1'b1;
        din_f   = 8'hC3;
        step();
        start_f = 1'b0;
        repeat (17) step();
        chk("fast_bit3_before_rst", tx_f, 1'b0);
        rst_f = 1'b0;
        #1;
        chk("fast_rst_tx_immediate", tx_f, 1'b1);
        chk("fast_rst_done", done_f, 1'b0);
        step();
        rst_f = 1'b1;
        repeat (40) begin
            step();
            chk("fast_post_rst_tx", tx_f, 1'b1);
            chk("fast_post_rst_done", done_f, 1'b0);
        end
        start_f = 1'b1;
        din_f   = 8'h3C;
        fast_frame(8'h3C, 1'b0);
        start_f = 1'b0;

        // Default rate, single-cycle start with 0xA7.
        chk("slow_idle_tx", tx_s, 1'b1);
        chk("slow_idle_done", done_s, 1'b0);
        start_s = 1'b1;
        din_s   = 8'hA7;
        step();
        start_s = 1'b0;
        din_s   = 8'h00;
        for (int b = 0; b < NBITS; b++) begin
            for (int c = 0; c < SLOW_CPB; c++) begin
                if (c == 0 || c == SLOW_CPB / 2 || c == SLOW_CPB - 1) begin
                    chk($sformatf("slow_bit%0d_c%0d", b, c), tx_s, A7_LINE[b]);
                    chk("slow_done_low", done_s, 1'b0);
                end
                step();
            end
        end
        chk("slow_done_pulse", done_s, 1'b1);
        chk("slow_done_tx_high", tx_s, 1'b1);
        step();
        chk("slow_done_one_cycle", done_s, 1'b0);
        chk("slow_idle_after", tx_s, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
